// File: rtl/fetch_unit.sv
// fetch_unit -- program counter sequencer for a small in-order core.
//
// Holds the fetch address (PC) for the instruction ROM and counts retired
// instructions. While Start is high the PC is loaded from Start_Addr; the
// falling edge of Start begins execution. Conditional branches, halt and
// stall decide the next PC. All outputs are registered.
//
// Ports
//   CLK         in   1  rising-edge clock
//   Reset       in   1  asynchronous active-high reset
//   Start       in   1  level; high loads Start_Addr, low lets execution run
//   Start_Addr  in   8  first instruction address
//   Branch      in   1  current instruction is a conditional branch
//   Zero        in   1  ALU zero flag of the current instruction
//   BrOffset    in   6  signed branch offset (two's complement)
//   Halt        in   1  current instruction is halt
//   Stall       in   1  freeze fetch this cycle
//   PC          out  8  address to the instruction ROM
//   InstrCount  out 16  retired-instruction count, saturating
//   Running     out  1  high in RUN
//   Done        out  1  high in DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | program start loaded (or just reset); waits for Start low
// RUN   | fetching; PC advances or branches on each unstalled cycle
// DONE  | halt retired; PC and count frozen until Start
module fetch_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Start_Addr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [5:0]  BrOffset,
  input  logic        Halt,
  input  logic        Stall,
  output logic [7:0]  PC,
  output logic [15:0] InstrCount,
  output logic        Running,
  output logic        Done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic [7:0]  nextPc;
  logic [15:0] nextCount;
  logic [15:0] retiredCount;
  logic [7:0]  branchTarget;

  // Halt retires too, so every unstalled RUN cycle bumps the count.
  assign retiredCount = (InstrCount == 16'hFFFF) ? InstrCount : InstrCount + 16'd1;
  // 8-bit add of the sign-extended offset wraps modulo 256.
  assign branchTarget = PC + {{2{BrOffset[5]}}, BrOffset};

  always_comb begin
    nextState = state;
    nextPc    = PC;
    nextCount = InstrCount;
    if (Start) begin
      nextState = IDLE;
      nextPc    = Start_Addr;
      nextCount = 16'd0;
    end else begin
      case (state)
        IDLE: nextState = RUN;
        RUN: begin
          if (!Stall) begin
            nextCount = retiredCount;
            if (Halt)
              nextState = DONE;
            else if (Branch && Zero)
              nextPc = branchTarget;
            else
              nextPc = PC + 8'd1;
          end
        end
        DONE: nextState = DONE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= 8'h00;
      InstrCount <= 16'd0;
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= nextState;
      PC         <= nextPc;
      InstrCount <= nextCount;
      Running    <= (nextState == RUN);
      Done       <= (nextState == DONE);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the sequencer.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  Start_Addr;
  logic        Branch;
  logic        Zero;
  logic [5:0]  BrOffset;
  logic        Halt;
  logic        Stall;
  logic [7:0]  PC;
  logic [15:0] InstrCount;
  logic        Running;
  logic        Done;

  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Start_Addr(Start_Addr),
    .Branch(Branch), .Zero(Zero), .BrOffset(BrOffset), .Halt(Halt),
    .Stall(Stall), .PC(PC), .InstrCount(InstrCount), .Running(Running),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // model: phase 0 = waiting to start, 1 = executing, 2 = halted
  int mPhase;
  int mPc;
  int mCount;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mPc = 0; mCount = 0;
  endtask

  // One clock edge of the sequencer, using the inputs as they stand now.
  task automatic modelStep();
    int off;
    if (Start) begin
      mPhase = 0; mPc = int'(Start_Addr); mCount = 0;
    end else if (mPhase == 0) begin
      mPhase = 1;
    end else if (mPhase == 1 && !Stall) begin
      if (mCount < 65535) mCount = mCount + 1;
      if (Halt) mPhase = 2;
      else if (Branch && Zero) begin
        off = int'(BrOffset);
        if (off >= 32) off = off - 64;
        mPc = (mPc + off + 256) % 256;
      end else mPc = (mPc + 1) % 256;
    end
  endtask

  task automatic compareAll(input string tag);
    check({tag, ".PC"}, int'(PC), mPc);
    check({tag, ".Count"}, int'(InstrCount), mCount);
    check({tag, ".Running"}, int'(Running), (mPhase == 1) ? 1 : 0);
    check({tag, ".Done"}, int'(Done), (mPhase == 2) ? 1 : 0);
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    modelStep();
    #1;
    compareAll(tag);
  endtask

  task automatic cycleQuiet();
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    Branch = 0; Zero = 0; BrOffset = 6'd0; Halt = 0; Stall = 0;
  endtask

  task automatic loadAndRun(input logic [7:0] addr);
    Start = 1; Start_Addr = addr; idleInputs();
    cycle("load");
    Start = 0;
    cycle("enter");
  endtask

  initial begin
    Reset = 1; Start = 0; Start_Addr = 8'h00; idleInputs();
    modelReset();
    #2;
    check("rst.PC", int'(PC), 0);
    check("rst.Count", int'(InstrCount), 0);
    check("rst.Running", int'(Running), 0);
    check("rst.Done", int'(Done), 0);
    Reset = 0;
    #5;

    // Start held two cycles at 0x10, then four free-running cycles
    Start = 1; Start_Addr = 8'h10;
    cycle("s19a"); cycle("s19b");
    check("s19.PC0", int'(PC), 8'h10);
    Start = 0;
    cycle("s19c"); check("s19.PC1", int'(PC), 8'h10);
    cycle("s19d"); check("s19.PC2", int'(PC), 8'h11);
    cycle("s19e"); check("s19.PC3", int'(PC), 8'h12);
    cycle("s19f"); check("s19.PC4", int'(PC), 8'h13);
    check("s19.Count", int'(InstrCount), 3);
    check("s19.Running", int'(Running), 1);

    // taken branch back by 4, then not-taken
    loadAndRun(8'h20);
    Branch = 1; Zero = 1; BrOffset = 6'b111100;
    cycle("br20"); check("br20.PC", int'(PC), 8'h1C);
    loadAndRun(8'h20);
    Branch = 1; Zero = 0; BrOffset = 6'b111100;
    cycle("nb20"); check("nb20.PC", int'(PC), 8'h21);

    // wrap cases and offset 0 self-loop
    loadAndRun(8'hFF);
    cycle("wrapFF"); check("wrapFF.PC", int'(PC), 8'h00);
    loadAndRun(8'h02);
    Branch = 1; Zero = 1; BrOffset = 6'b111100;
    cycle("wrap02"); check("wrap02.PC", int'(PC), 8'hFE);
    BrOffset = 6'd0;
    cycle("self"); check("self.PC", int'(PC), 8'hFE);
    BrOffset = 6'd31;
    cycle("fwd31"); check("fwd31.PC", int'(PC), 8'h1D);

    // halt beats branch; DONE freezes; Start clears
    loadAndRun(8'h30);
    Halt = 1; Branch = 1; Zero = 1; BrOffset = 6'd5;
    cycle("halt");
    check("halt.Done", int'(Done), 1);
    check("halt.PC", int'(PC), 8'h30);
    check("halt.Count", int'(InstrCount), 1);
    Halt = 0; Stall = 1;
    repeat (3) cycle("doneHold");
    Stall = 0;
    cycle("doneHold2");
    Start = 1; Start_Addr = 8'h30;
    cycle("doneStart");
    check("doneStart.Done", int'(Done), 0);
    check("doneStart.Count", int'(InstrCount), 0);
    Start = 0;

    // stall holds against a pending taken branch
    loadAndRun(8'h40);
    Branch = 1; Zero = 1; BrOffset = 6'd4; Stall = 1;
    repeat (3) cycle("stall");
    check("stall.PC", int'(PC), 8'h40);
    check("stall.Count", int'(InstrCount), 0);
    Stall = 0;
    cycle("unstall"); check("unstall.PC", int'(PC), 8'h44);

    // async reset between edges mid-run
    loadAndRun(8'h54);
    idleInputs();
    cycle("pre55"); check("pre55.PC", int'(PC), 8'h55);
    #2; Reset = 1; #1;
    modelReset();
    compareAll("asyncRst");
    Reset = 0;
    cycle("postRst");
    check("postRst.Running", int'(Running), 1);
    check("postRst.PC", int'(PC), 8'h00);

    // count saturation after a long run
    loadAndRun(8'h00);
    idleInputs();
    repeat (65540) cycleQuiet();
    compareAll("sat");
    check("sat.Count", int'(InstrCount), 16'hFFFF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Start      = ($urandom_range(0, 39) == 0);
      Start_Addr = 8'($urandom);
      Branch     = 1'($urandom);
      Zero       = 1'($urandom);
      BrOffset   = 6'($urandom);
      Halt       = ($urandom_range(0, 29) == 0);
      Stall      = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
